// File: rtl/aud_play_feeder.sv
// Playback sequencer feeding the I2S DAC serializer: SRAM reads, fast skip, slow hold/interp.
// Define AUD_FEEDER_INTERP_EN to compile in the linear-interpolation datapath.
module aud_play_feeder #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic              i_rst_n,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic [2:0]        i_speed,
  input  logic              i_interp,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  input  logic [15:0]       i_sram_data,
  output logic [15:0]       o_dac_data,
  output logic              o_en,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    StIdle, StRdA, StRdB, StCapA, StCapB, StCalc, StReady, StFinish
  } state_e;

  state_e            state_q;
  logic              lrck_q;
  logic              fast_q;
  logic [2:0]        speed_q;
  logic [ADDR_W-1:0] end_q;
  logic [ADDR_W:0]   j_q;
  logic [2:0]        k_q;
  logic [15:0]       a_q;
  logic [15:0]       next_q;

  logic              tick;
  logic [3:0]        n_fac;
  logic              last_phase;
  logic              move;
  logic              is_last;
  logic [ADDR_W:0]   j_adv;
  logic [ADDR_W:0]   j_inc;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       calc_val;

  assign tick       = i_daclrck & ~lrck_q;
  assign n_fac      = {1'b0, speed_q} + 4'd1;
  assign last_phase = (k_q == speed_q);
  assign move       = fast_q | last_phase;
  assign j_adv      = fast_q ? j_q + {{(ADDR_W-3){1'b0}}, n_fac}
                             : j_q + {{ADDR_W{1'b0}}, last_phase};
  // One extra address bit so that stepping past the end never wraps.
  assign is_last    = move && (j_adv > {1'b0, end_q});
  assign j_inc      = j_q + {{ADDR_W{1'b0}}, 1'b1};
  assign b_addr     = (j_inc > {1'b0, end_q}) ? j_q[ADDR_W-1:0] : j_inc[ADDR_W-1:0];

`ifdef AUD_FEEDER_INTERP_EN
  logic               interp_q;
  logic [15:0]        b_q;
  logic [12:0]        ratio;
  logic [15:0]        kr;
  logic signed [16:0] diff;
  logic signed [33:0] diff_x;
  logic signed [33:0] kr_x;
  logic signed [33:0] prod;
  logic signed [33:0] sum;
  logic [15:0]        interp_val;

  // ratio ~= 4096 / N, so k * ratio >> 12 is the fractional position k / N.
  always_comb begin
    case (speed_q)
      3'd0:    ratio = 13'd4096;
      3'd1:    ratio = 13'd2048;
      3'd2:    ratio = 13'd1365;
      3'd3:    ratio = 13'd1024;
      3'd4:    ratio = 13'd819;
      3'd5:    ratio = 13'd683;
      3'd6:    ratio = 13'd585;
      default: ratio = 13'd512;
    endcase
  end

  assign kr     = {13'd0, k_q} * {3'd0, ratio};
  assign diff   = $signed({b_q[15], b_q}) - $signed({a_q[15], a_q});
  assign diff_x = {{17{diff[16]}}, diff};
  assign kr_x   = $signed({18'd0, kr});
  assign prod   = diff_x * kr_x;
  assign sum    = (prod >>> 12) + $signed({{18{a_q[15]}}, a_q});

  always_comb begin
    if (sum > 34'sd32767) begin
      interp_val = 16'h7fff;
    end else if (sum < -34'sd32768) begin
      interp_val = 16'h8000;
    end else begin
      interp_val = sum[15:0];
    end
  end

  always_comb begin
    calc_val = a_q;
    if (!fast_q && interp_q) begin
      calc_val = interp_val;
    end
  end
`else
  logic unused_interp;
  assign unused_interp = i_interp;

  always_comb begin
    calc_val = a_q;
  end
`endif

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      lrck_q      <= 1'b1;
      fast_q      <= 1'b0;
      speed_q     <= 3'd0;
      end_q       <= '0;
      j_q         <= '0;
      k_q         <= 3'd0;
      a_q         <= 16'd0;
      next_q      <= 16'd0;
      o_sram_addr <= '0;
      o_dac_data  <= 16'd0;
      o_en        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
`ifdef AUD_FEEDER_INTERP_EN
      interp_q    <= 1'b0;
      b_q         <= 16'd0;
`endif
    end else begin
      lrck_q <= i_daclrck;
      o_en   <= 1'b0;
      o_done <= 1'b0;
      if (i_stop) begin
        state_q    <= StIdle;
        o_busy     <= 1'b0;
        o_dac_data <= 16'd0;
        k_q        <= 3'd0;
      end else begin
        case (state_q)
          StIdle: begin
            if (i_start) begin
              fast_q   <= i_fast;
              speed_q  <= i_speed;
              end_q    <= i_end_addr;
`ifdef AUD_FEEDER_INTERP_EN
              interp_q <= i_interp;
`endif
              j_q      <= '0;
              k_q      <= 3'd0;
              o_busy   <= 1'b1;
              state_q  <= StRdA;
            end
          end
          StRdA: begin
            o_sram_addr <= j_q[ADDR_W-1:0];
            state_q     <= StRdB;
          end
          StRdB: begin
            o_sram_addr <= b_addr;
            state_q     <= StCapA;
          end
          StCapA: begin
            a_q     <= i_sram_data;
            state_q <= StCapB;
          end
          StCapB: begin
`ifdef AUD_FEEDER_INTERP_EN
            b_q     <= i_sram_data;
`endif
            state_q <= StCalc;
          end
          StCalc: begin
            next_q  <= calc_val;
            state_q <= StReady;
          end
          StReady: begin
            if (tick && !i_pause) begin
              o_en       <= 1'b1;
              o_dac_data <= next_q;
              if (is_last) begin
                state_q <= StFinish;
              end else if (move) begin
                j_q     <= j_adv;
                k_q     <= 3'd0;
                state_q <= StRdA;
              end else begin
                k_q     <= k_q + 3'd1;
                state_q <= StCalc;
              end
            end
          end
          StFinish: begin
            o_done     <= 1'b1;
            o_busy     <= 1'b0;
            o_dac_data <= 16'd0;
            state_q    <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_play_feeder.sv
// Directed bench for aud_play_feeder: free-running 32-BCLK frames and a registered SRAM model.
module tb_aud_play_feeder;

  localparam int unsigned AW = 20;

  logic          rst_n;
  logic          clk;
  logic          lrck;
  logic          start;
  logic          pause;
  logic          stop;
  logic          fast;
  logic [2:0]    speed;
  logic          interp;
  logic [AW-1:0] end_addr;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_data;
  logic [15:0]   dac_data;
  logic          en;
  logic          busy;
  logic          done;

  logic [15:0]   mem [16];
  logic [4:0]    lr_cnt;
  int            n_pass;
  int            n_checks;

  aud_play_feeder #(.ADDR_W(AW)) dut (
    .i_rst_n     (rst_n),
    .i_bclk      (clk),
    .i_daclrck   (lrck),
    .i_start     (start),
    .i_pause     (pause),
    .i_stop      (stop),
    .i_fast      (fast),
    .i_speed     (speed),
    .i_interp    (interp),
    .i_end_addr  (end_addr),
    .o_sram_addr (sram_addr),
    .i_sram_data (sram_data),
    .o_dac_data  (dac_data),
    .o_en        (en),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial lr_cnt = 5'd7;
  always @(negedge clk) lr_cnt <= lr_cnt + 5'd1;
  assign lrck = lr_cnt[4];

  // Synchronous SRAM: data for an address appears one cycle after it is presented.
  always @(posedge clk) sram_data <= mem[sram_addr[3:0]];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Waits (bounded) for an o_en pulse, checks the sample, then steps one cycle past it.
  task automatic wait_en(input string tag, input int exp);
    int cyc = 0;
    while (en !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (en === 1'b1) check(tag, $signed(dac_data), exp);
    else check({tag, "_timeout"}, 32'sd99999, exp);
    @(negedge clk);
  endtask

  task automatic start_play(input logic f, input logic [2:0] sp, input logic ip,
                            input logic [AW-1:0] ea);
    fast     = f;
    speed    = sp;
    interp   = ip;
    end_addr = ea;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_dac_zero"}, $signed(dac_data), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cnt;
    int exp3 [4];
    int exp4 [6];
    n_pass   = 0;
    n_checks = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    fast     = 1'b0;
    speed    = 3'd0;
    interp   = 1'b0;
    end_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'd0;

    repeat (3) @(negedge clk);
    check("rst_dac", $signed(dac_data), 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", sram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // N=1 hold
    mem[0] = 16'd100;
    mem[1] = 16'd200;
    mem[2] = 16'(-300);
    mem[3] = 16'd400;
    start_play(1'b0, 3'd0, 1'b0, 20'd3);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_addr0", sram_addr, 0);
    @(negedge clk);
    check("t1_addr1", sram_addr, 1);
    wait_en("t1_s0", 100);
    wait_en("t1_s1", 200);
    wait_en("t1_s2", -300);
    wait_en("t1_s3", 400);
    check_done("t1");

    // Fast N=2
    for (int i = 0; i < 6; i++) mem[i] = 16'(10 * i);
    start_play(1'b1, 3'd1, 1'b1, 20'd5);
    @(negedge clk);
    check("t2_addr0", sram_addr, 0);
    @(negedge clk);
    check("t2_addr1", sram_addr, 1);
    wait_en("t2_s0", 0);
    wait_en("t2_s1", 20);
    wait_en("t2_s2", 40);
    check_done("t2");

    // Slow N=2 interp
`ifdef AUD_FEEDER_INTERP_EN
    exp3 = '{0, 50, 100, 100};
    exp4 = '{0, -34, -67, -100, -100, -100};
`else
    exp3 = '{0, 0, 100, 100};
    exp4 = '{0, 0, 0, -100, -100, -100};
`endif
    mem[0] = 16'd0;
    mem[1] = 16'd100;
    start_play(1'b0, 3'd1, 1'b1, 20'd1);
    for (int i = 0; i < 4; i++) wait_en($sformatf("t3_s%0d", i), exp3[i]);
    check_done("t3");

    // Slow N=3 interp, negative slope
    mem[1] = 16'(-100);
    start_play(1'b0, 3'd2, 1'b1, 20'd1);
    for (int i = 0; i < 6; i++) wait_en($sformatf("t4_s%0d", i), exp4[i]);
    check_done("t4");

    // Pause across two ticks, then stop
    for (int i = 0; i < 10; i++) mem[i] = 16'(i + 1);
    start_play(1'b0, 3'd0, 1'b0, 20'd9);
    wait_en("t5_s0", 1);
    wait_en("t5_s1", 2);
    pause = 1'b1;
    cnt = 0;
    repeat (64) begin
      @(negedge clk);
      if (en === 1'b1) cnt++;
    end
    check("t5_pause_no_en", cnt, 0);
    check("t5_pause_hold", $signed(dac_data), 2);
    check("t5_pause_busy", busy, 1);
    pause = 1'b0;
    wait_en("t5_s2", 3);
    wait_en("t5_s3", 4);
    wait_en("t5_s4", 5);
    wait_en("t5_s5", 6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t5_stop_busy", busy, 0);
    check("t5_stop_en", en, 0);
    check("t5_stop_dac", $signed(dac_data), 0);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1 || en === 1'b1) cnt++;
    end
    check("t5_stop_no_done", cnt, 0);

    // Second start while busy is ignored
    mem[0] = 16'd100;
    mem[1] = 16'd200;
    mem[2] = 16'(-300);
    mem[3] = 16'd400;
    start_play(1'b0, 3'd0, 1'b0, 20'd3);
    wait_en("t6_s0", 100);
    start_play(1'b1, 3'd3, 1'b0, 20'd9);
    wait_en("t6_s1", 200);
    wait_en("t6_s2", -300);
    wait_en("t6_s3", 400);
    check_done("t6");

    // Asynchronous reset mid-frame
    start_play(1'b0, 3'd0, 1'b0, 20'd3);
    wait_en("t7_s0", 100);
    repeat (10) @(negedge clk);
    check("t7_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_rst_dac", $signed(dac_data), 0);
    check("t7_rst_en", en, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_addr", sram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aud_play_feeder.md
# aud_play_feeder

Playback sample sequencer that sits directly upstream of the I2S DAC serializer. It reads 16-bit signed samples from SRAM and applies fast playback (sample skipping) or slow playback (hold or linear interpolation). Once per DACLRCK frame it presents one stable sample plus a one-cycle enable to the serializer. It runs entirely in the BCLK domain.

## Interface
- ADDR_W, 20, SRAM word-address width
- i_rst_n  in  1  asynchronous, active-low reset
- i_bclk  in  1  codec bit clock; all state updates on rising edge
- i_daclrck  in  1  codec DAC LR clock; a frame starts at its rising edge
- i_start  in  1  begin playback from address 0 (honoured only in IDLE)
- i_pause  in  1  level; freezes playback position
- i_stop  in  1  abort playback immediately
- i_fast  in  1  1 = fast mode, 0 = slow mode (latched at start)
- i_speed  in  3  factor N = i_speed+1, range 1..8 (latched at start)
- i_interp  in  1  slow mode only: 1 = linear interpolation, 0 = hold (latched at start)
- i_end_addr  in  ADDR_W  last valid sample address, inclusive (latched at start)
- o_sram_addr  out  ADDR_W  SRAM read address; data is valid on i_sram_data one cycle later
- i_sram_data  in  16  SRAM read data, signed
- o_dac_data  out  16  signed sample to the serializer; held constant for a full frame
- o_en  out  1  one-cycle pulse: o_dac_data is valid for this frame
- o_busy  out  1  high from start acceptance until done or stop
- o_done  out  1  one-cycle pulse when the final frame has been issued

## Operation
- Reset values: o_dac_data=0, o_en=0, o_sram_addr=0, o_busy=0, o_done=0, state IDLE.
- Tick: i_daclrck=1 at the current edge and 0 at the previous edge; this uses a one-register edge detector. The detector register resets to 1, so no tick occurs on the first edge after reset.
- States: IDLE -> PREFETCH (read A=s[0], then B=s[1]) -> READY (next value computed, waiting for tick) -> on tick: emit, advance, FETCH if needed -> READY ... -> IDLE.
- Sample registers: A=s[j], B=s[j+1]. If j+1 > end, B=s[j]. Frame phase k runs from 0 to N-1.
- Fast mode: the m-th emitted sample is s[m*N]. After each tick, j += N.
- Slow hold: emit s[j] for N consecutive ticks, then j += 1.
- Slow interp: emit A + ((B-A)*k*R[N]) >>> 12.
  - R[1..8] = 4096, 2048, 1365, 1024, 819, 683, 585, 512.
  - diff is 17-bit signed. The product is at least 33-bit signed.
  - >>> is an arithmetic shift (floor).
  - The sum is saturated to [-32768, 32767].
- Termination: when the advanced j exceeds i_end_addr, the current tick is the last. o_done pulses on the cycle after that tick, o_busy drops on the same cycle, o_dac_data returns to 0, and the state returns to IDLE. Address compare uses ADDR_W+1 bits, so there is no wrap-around.
- Pause: a tick seen while i_pause=1 gives no o_en, no advance and no k change; o_dac_data is held. Playback resumes at the first tick with i_pause=0.
- Stop: i_stop forces IDLE on the next edge from any state. o_busy=0, o_en=0, o_dac_data=0, and no o_done.
- Priority: stop > start > pause.
- i_start while busy is ignored. i_start with stop asserted on the same edge is ignored.
- i_end_addr=0 plays a single sample (N frames in slow mode).

## Timing
- Start accepted at edge t0. Reads for s[0] and s[1] are issued at t0+1 and t0+2. READY is reached no later than t0+6.
- The first o_en is on the first tick at or after t0+6.
- o_en and the new o_dac_data are registered on the same edge as the tick detection. That is one cycle after the DACLRCK rise, which is well ahead of the serializer's low-phase read.
- The next sample fetch and calculation must complete within 6 cycles after each tick. A frame is always at least 32 BCLK, so this bound always holds.
- The SRAM address is driven only during PREFETCH/FETCH and holds otherwise.

## Configuration
- AUD_FEEDER_INTERP_EN
  - Defined: the interpolation datapath (multiply, R ROM, saturation) is compiled in, and i_interp selects between hold and interp.
  - Undefined: i_interp is ignored and slow mode always uses hold.

## Test plan
- N=1, s=[100,200,-300,400], end=3 -> o_en on 4 consecutive ticks with 100, 200, -300, 400; o_done 1 cycle after the 4th tick; o_dac_data=0.
- Fast, i_speed=1, s[i]=10*i, end=5 -> outputs 0, 20, 40, then o_done.
- Slow N=2, interp, s=[0,100], end=1 -> 0, 50, 100, 100 with the macro defined; 0, 0, 100, 100 with it undefined.
- Slow N=3, interp, s=[0,-100], end=1 -> 0, -34, -67, -100, -100, -100 (floor rounding).
- N=1, s=[1..10]: pause held across ticks 3-4 -> no o_en on those ticks and the output sequence continues at 3. Stop after tick 6 -> o_busy=0 next cycle and no o_done.
- Reset asserted mid-frame -> all outputs at reset values immediately; a second i_start while busy -> no restart, sequence unchanged.
